// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: write-only digit store, fixed-rate scan, registered active-low pins.
// Optional leading-zero suppression on digits 3..1 is enabled by defining DISP_LEADING_BLANK_EN.
module seg7_scan_driver #(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [10:0] data_in,
    output logic [11:0] data_out
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [4:0] CODE_BLANK = 5'h11;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [4:0]       code_q [4];
    logic [4:0]       code_d [4];
    logic [3:0]       dp_q, dp_d;
    logic [11:0]      out_q, out_d;
    logic [3:0]       zero_sup;
    logic             hi_blank;
    logic [4:0]       cur_code;
    logic [6:0]       cur_seg;
    logic             unused_bits;

    assign unused_bits = ^data_in[7:5];

    // g..a, 1 = lit
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00: seg_decode = 7'h3F;
            5'h01: seg_decode = 7'h06;
            5'h02: seg_decode = 7'h5B;
            5'h03: seg_decode = 7'h4F;
            5'h04: seg_decode = 7'h66;
            5'h05: seg_decode = 7'h6D;
            5'h06: seg_decode = 7'h7D;
            5'h07: seg_decode = 7'h07;
            5'h08: seg_decode = 7'h7F;
            5'h09: seg_decode = 7'h6F;
            5'h0A: seg_decode = 7'h77;
            5'h0B: seg_decode = 7'h7C;
            5'h0C: seg_decode = 7'h39;
            5'h0D: seg_decode = 7'h5E;
            5'h0E: seg_decode = 7'h79;
            5'h0F: seg_decode = 7'h71;
            5'h10: seg_decode = 7'h40;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
        code_d = code_q;
        dp_d   = dp_q;
        if (sel) begin
            code_d[data_in[10:9]] = data_in[4:0];
            dp_d[data_in[10:9]]   = data_in[8];
        end
    end

    // A digit is suppressed when it is zero and everything to its left already shows no segments.
    always_comb begin
        zero_sup = '0;
        hi_blank = 1'b1;
`ifdef DISP_LEADING_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            zero_sup[i] = hi_blank && (code_q[i] == 5'h00);
            hi_blank    = hi_blank && ((code_q[i] == 5'h00) || (code_q[i] >= CODE_BLANK));
        end
`endif
    end

    always_comb begin
        cur_code = code_q[idx_q];
        cur_seg  = zero_sup[idx_q] ? 7'h00 : seg_decode(cur_code);
        out_d    = {~(4'b0001 << idx_q), ~dp_q[idx_q], ~cur_seg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            dp_q  <= '0;
            out_q <= 12'hFFF;
            for (int i = 0; i < 4; i++) begin
                code_q[i] <= CODE_BLANK;
            end
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dp_q   <= dp_d;
            out_q  <= out_d;
            code_q <= code_d;
        end
    end

    assign data_out = out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: edge-count scan model plus literal pins on key display values.
// Compile with DISP_LEADING_BLANK_EN defined to exercise leading-zero suppression.
module tb_seg7_scan_driver;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic [10:0] data_in = '0;
    logic [11:0] data_out;

    seg7_scan_driver #(.REFRESH_CYCLES(RC)) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .data_in(data_in),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Active-low a..g plus dp-off bit for codes 0x00..0x10
    logic [7:0] seg_lo [17] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hBF};

    int          m_code [4];
    bit          m_dp   [4];
    int          m_n = 0;
    logic [11:0] m_exp = 12'hFFF;

    int          checks = 0;
    int          errors = 0;
    logic        pin_en = 1'b0;
    logic [11:0] pin_val = '0;
    string       pin_name = "";

    function automatic logic [11:0] model_out(input int n);
        int d;
        logic [7:0] b;
`ifdef DISP_LEADING_BLANK_EN
        bit hi_clear;
`endif
        d = (n / RC) % 4;
        b = (m_code[d] <= 16) ? seg_lo[m_code[d]] : 8'hFF;
`ifdef DISP_LEADING_BLANK_EN
        if (d > 0 && m_code[d] == 0) begin
            hi_clear = 1'b1;
            for (int j = d + 1; j < 4; j++)
                if (m_code[j] != 0 && m_code[j] <= 16) hi_clear = 1'b0;
            if (hi_clear) b = 8'hFF;
        end
`endif
        if (m_dp[d]) b[7] = 1'b0;
        model_out = {~(4'b0001 << d), b};
    endfunction

    // Output after edge n reflects scan position and storage as they stood before that edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n   <= 0;
            m_exp <= 12'hFFF;
            for (int i = 0; i < 4; i++) begin
                m_code[i] <= 17;
                m_dp[i]   <= 1'b0;
            end
        end else begin
            m_exp <= model_out(m_n);
            if (sel) begin
                m_code[data_in[10:9]] <= int'(data_in[4:0]);
                m_dp[data_in[10:9]]   <= data_in[8];
            end
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin : compare
        int nc;
        int ne;
        nc = 1;
        ne = 0;
        if (data_out !== m_exp) begin
            ne++;
            $display("FAIL model t=%0t: data_out=%h expected=%h", $time, data_out, m_exp);
        end
        if (pin_en) begin
            nc++;
            if (data_out !== pin_val) begin
                ne++;
                $display("FAIL %s: data_out=%h expected=%h", pin_name, data_out, pin_val);
            end
        end
        checks <= checks + nc;
        errors <= errors + ne;
    end

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pin(input string nm, input logic [11:0] v);
        pin_name = nm;
        pin_val  = v;
        pin_en   = 1'b1;
        @(negedge clk);
        #1;
        pin_en   = 1'b0;
    endtask

    task automatic wr(input logic [10:0] w);
        sel     = 1'b1;
        data_in = w;
        step(1);
        sel     = 1'b0;
    endtask

    initial begin
        pin("reset_hold", 12'hFFF);
        rst = 1'b1;
        pin("first_edge", 12'hEFF);
        step(3); pin("anode_d1", 12'hDFF);
        step(3); pin("anode_d2", 12'hBFF);
        step(3); pin("anode_d3", 12'h7FF);
        step(3); pin("anode_wrap", 12'hEFF);

        wr(11'h003);
        pin("wr_d0_next", 12'hEB0);
        wr(11'h510);
        wr(11'h21F);
        wr(11'h211);
        wr(11'h608);
        pin("d1_blank", 12'hDFF);
        pin("d2_minus_dp", 12'hB3F);
        step(3); pin("d3_eight", 12'h780);

        wr(11'h000);
        wr(11'h200);
        wr(11'h400);
        wr(11'h600);
        pin("zeros_d0", 12'hEC0);
`ifdef DISP_LEADING_BLANK_EN
        step(2); pin("zeros_d1", 12'hDFF);
        step(3); pin("zeros_d2", 12'hBFF);
`else
        step(2); pin("zeros_d1", 12'hDC0);
        step(3); pin("zeros_d2", 12'hBC0);
`endif
        wr(11'h405);
        pin("d2_five", 12'hB92);
`ifdef DISP_LEADING_BLANK_EN
        step(1); pin("d3_lead", 12'h7FF);
`else
        step(1); pin("d3_lead", 12'h7C0);
`endif
        step(7); pin("d1_after5", 12'hDC0);

        step(4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        pin("reset_async", 12'hFFF);
        rst = 1'b1;
        pin("restart_d0", 12'hEFF);
        step(3); pin("restart_d1", 12'hDFF);
        step(3); pin("restart_d2", 12'hBFF);
        step(3); pin("restart_d3", 12'h7FF);

        for (int c = 0; c < 32; c++) begin
            for (int d = 0; d < 4; d++) begin
                wr({2'(d), 1'(c & 1), 3'b101, 5'(c)});
            end
        end
        step(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
